sprite_plotter: RTL and testbench
=================================

# sprite_plotter

Pixel-sequencing responder for the game's sprite draw requests. The game FSM issues one request naming a sprite kind (press or garbage), a slot position and draw/erase. This block serialises the request into one VGA adapter plot per clock (`x`, `y`, `colour`, `writeEn`) and reports completion with a `done` pulse, so callers do not have to wait a fixed delay. It sits between the game FSM and `vga_adapter`, and holds one pending request so the FSM can queue the next draw while the current one is in progress.

## Interface
- `SIZE`, 16: sprite edge in pixels; every sprite is a SIZE×SIZE square.
- `PITCH`, 24: horizontal distance in pixels between adjacent slot origins.
- `X0`, 8: x origin of slot 0.
- `PRESS_Y`, 20: y origin of the press row.
- `GARB_Y`, 80: y origin of the garbage row.

Ports:
- `CLOCK_50` in 1: sole clock; every register updates on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: a request is presented this cycle.
- `req_ready` out 1: the block can accept a request this cycle; equals `!pend_full` (combinational).
- `req_item` in 1: 1 = press sprite, 0 = garbage sprite.
- `req_erase` in 1: 1 = paint black, 0 = paint the sprite colour.
- `req_position` in 3: slot index.
- `busy` out 1: high while a request is active (states DRAW and DONE).
- `done` out 1: one-cycle pulse when a request completes.
- `x` out 8, `y` out 7: pixel coordinate on the 160x120 grid.
- `colour` out 3: pixel colour.
- `writeEn` out 1: plot strobe.

## Operation
- **Handshake:** a request is accepted on an edge where `req_valid && req_ready`. All request fields are latched on that edge; later changes to the inputs have no effect.
- **Request routing:**
  - In IDLE, an accepted request becomes the active request immediately.
  - In DRAW or DONE, an accepted request goes to the one-entry pending buffer and sets `pend_full`.
- **Valid slots:**
  - Press (`req_item=1`): positions 0–5.
  - Garbage (`req_item=0`): positions 0–3.
  - Anything else is a null request, including garbage 3'b111 ("no garbage"). A null request is accepted, produces no plots and completes through DONE.
- **Sprite origin:**
  - `ox = X0 + position*PITCH`, computed 8 bits wide.
  - `oy = PRESS_Y` for press, `GARB_Y` for garbage.
- **Colour:**
  - Any erase: 3'b000.
  - Press draw: 3'b111.
  - Garbage draw: 3'b010, except the 1-pixel border ring, which is 3'b110.
- **Scan order:** raster, with column counter `cx` (0..SIZE-1) fastest and row counter `cy` (0..SIZE-1).
  - Output per pixel: `x = ox+cx`, `y = oy+cy`.
  - All outputs are registered.
- **State machine:**
  - IDLE: `writeEn=0`, `busy=0`.
    - Valid request accepted → DRAW with `cx=cy=0`.
    - Null request accepted → DONE.
  - DRAW: one plot per cycle.
    - When `cx` wraps, `cy` increments.
    - After the plot at (`cx`,`cy`) = (SIZE-1, SIZE-1) → DONE.
  - DONE: `done=1`, `writeEn=0` for exactly one cycle.
    - If `pend_full`: the pending request moves to active, `pend_full` clears, and the state becomes DRAW (or DONE again if the pending request is null).
    - Otherwise → IDLE.
- **Simultaneous events:** in DONE with `pend_full=1`, `req_ready` is 0, so no new request can be accepted that cycle. The buffer frees on the following edge.
- **Reset:**
  - Values: `x=0`, `y=0`, `colour=0`, `writeEn=0`, `done=0`, `busy=0`, `pend_full=0`, counters 0, state IDLE.
  - Reset asserted mid-DRAW stops plotting on the next edge, drops both the active and pending requests, and produces no `done`.
  - A request presented while `reset_n=0` is not accepted.

## Timing
- Request accepted at edge 0, valid request:
  - First plot (`writeEn=1`) visible after edge 1.
  - Pixel k (0-based) appears after edge k+1.
  - Last plot appears after edge SIZE² (256 with defaults).
  - `done` is high after edge SIZE²+1.
- Null request accepted at edge 0: `done` high after edge 1; `writeEn` never asserts.
- Back-to-back with a pending valid request:
  - The first plot of the next request appears after edge SIZE²+2.
  - Exactly one non-plot cycle (the DONE cycle) separates the two requests.
- Throughput: one pixel per clock; there are no stall inputs.
- `busy` rises after the accept edge and falls after the DONE edge when nothing is pending.
- `writeEn` is never high in IDLE or DONE.

## Test plan
- **Reset values:** hold `reset_n=0` for 3 cycles → all outputs 0 and `req_ready=1`.
- **Press draw:** accept `req_item=1`, `req_erase=0`, `req_position=5` → 256 consecutive plots, colour 7.
  - First plot at (128,20); last plot at (143,35).
  - `done` after edge 257.
- **Garbage draw:** accept `req_item=0`, `req_erase=0`, `req_position=2` → 256 plots from (56,80) to (71,95).
  - Colour 6 on the border ring (60 pixels), e.g. (56,80) and (71,95).
  - Colour 2 on the interior (196 pixels), e.g. (57,81).
- **Null request:** accept garbage position 7 → zero plots, `done` after edge 1, back to IDLE after edge 2.
  - Repeat with press position 6 → same result.
- **Queueing:**
  - Request A = press 0 draw; request B = press 0 erase, accepted at pixel 10 of A.
  - Request C is presented while B is pending → `req_ready=0`, C is not accepted.
  - Expected plots: 256 of A, one DONE cycle, then B's first plot (8,20) with colour 0 after edge 258.
  - Exactly two `done` pulses.
- **Reset mid-draw:** assert reset at pixel 100 with a request pending → `writeEn` low after the next edge, no `done`, and no further plots after `reset_n` returns high.

Source files
------------

// File: rtl/sprite_plotter.sv
// sprite_plotter: serialises sprite draw/erase requests into one VGA plot per clock,
// with a one-entry pending buffer and a done pulse per completed request.
module sprite_plotter #(
  parameter int SIZE    = 16,
  parameter int PITCH   = 24,
  parameter int X0      = 8,
  parameter int PRESS_Y = 20,
  parameter int GARB_Y  = 80
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_item,
  input  logic       req_erase,
  input  logic [2:0] req_position,
  output logic       busy,
  output logic       done,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       writeEn
);
  localparam int CW = $clog2(SIZE);
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
  state_t state_q, state_d;
  logic act_item_q, act_erase_q, pend_full_q, pend_item_q, pend_erase_q;
  logic [2:0] act_pos_q, pend_pos_q;
  logic [CW-1:0] cx_q, cy_q;
  logic accept, req_ok, pend_ok, load_pend, take_req, last_col, last_row, border;
  logic [7:0] ox;
  logic [6:0] oy;
  always_comb begin
    req_ready = !pend_full_q;
    accept    = req_valid && req_ready;
    req_ok    = req_item ? req_position <= 3'd5 : req_position <= 3'd3;
    pend_ok   = pend_item_q ? pend_pos_q <= 3'd5 : pend_pos_q <= 3'd3;
    // a pending request is promoted from DONE, or from IDLE if it arrived during DONE
    load_pend = state_q != DRAW && pend_full_q;
    take_req  = state_q == IDLE && accept;
    last_col  = cx_q == CW'(SIZE - 1);
    last_row  = cy_q == CW'(SIZE - 1);
    border    = cx_q == '0 || cy_q == '0 || last_col || last_row;
    ox        = 8'(X0) + 8'(act_pos_q) * 8'(PITCH);
    oy        = act_item_q ? 7'(PRESS_Y) : 7'(GARB_Y);
    state_d   = load_pend ? (pend_ok ? DRAW : DONE) :
                take_req ? (req_ok ? DRAW : DONE) :
                state_q == DRAW ? (last_col && last_row ? DONE : DRAW) : IDLE;
  end
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      act_item_q   <= 1'b0;
      act_erase_q  <= 1'b0;
      act_pos_q    <= '0;
      pend_full_q  <= 1'b0;
      pend_item_q  <= 1'b0;
      pend_erase_q <= 1'b0;
      pend_pos_q   <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      x            <= '0;
      y            <= '0;
      colour       <= '0;
      writeEn      <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= state_d != IDLE;
      writeEn <= state_q == DRAW;
      done    <= state_q == DONE;
      if (state_q == DRAW) begin
        x      <= ox + 8'(cx_q);
        y      <= oy + 7'(cy_q);
        colour <= act_erase_q ? 3'b000 : act_item_q ? 3'b111 : border ? 3'b110 : 3'b010;
        cx_q   <= last_col ? '0 : cx_q + 1'b1;
        if (last_col) cy_q <= last_row ? '0 : cy_q + 1'b1;
      end
      if (load_pend) begin
        act_item_q  <= pend_item_q;
        act_erase_q <= pend_erase_q;
        act_pos_q   <= pend_pos_q;
        pend_full_q <= 1'b0;
      end else if (take_req) begin
        act_item_q  <= req_item;
        act_erase_q <= req_erase;
        act_pos_q   <= req_position;
      end else if (accept) begin
        pend_item_q  <= req_item;
        pend_erase_q <= req_erase;
        pend_pos_q   <= req_position;
        pend_full_q  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sprite_plotter.sv
// tb_sprite_plotter: directed checks of sprite_plotter plots, handshake, queueing and reset.
module tb_sprite_plotter;
  logic CLOCK_50 = 1'b0, reset_n = 1'b0, req_valid = 1'b0, req_item = 1'b0, req_erase = 1'b0;
  logic [2:0] req_position = '0;
  logic req_ready, busy, done, writeEn;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  int checks = 0, errors = 0;
  always #5 CLOCK_50 = ~CLOCK_50;
  sprite_plotter dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_item(req_item), .req_erase(req_erase), .req_position(req_position), .busy(busy),
    .done(done), .x(x), .y(y), .colour(colour), .writeEn(writeEn)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask
  task automatic send(input logic item, input logic erase, input logic [2:0] pos);
    req_valid = 1'b1; req_item = item; req_erase = erase; req_position = pos;
    tick;
    req_valid = 1'b0;
  endtask
  task automatic draw(input logic item, input logic erase, input logic [2:0] pos);
    int ox, oy, c, n6, n2;
    ox = 8 + pos * 24; oy = item ? 20 : 80; n6 = 0; n2 = 0;
    send(item, erase, pos);
    check("busy_accept", busy, 1);
    check("we_accept", writeEn, 0);
    for (int cy = 0; cy < 16; cy++)
      for (int cx = 0; cx < 16; cx++) begin
        tick;
        c = erase ? 0 : item ? 7 : (cx == 0 || cx == 15 || cy == 0 || cy == 15) ? 6 : 2;
        check("we_pixel", writeEn, 1);
        check("x_pixel", x, ox + cx);
        check("y_pixel", y, oy + cy);
        check("colour_pixel", colour, c);
        check("done_early", done, 0);
        if (colour == 3'd6) n6++;
        if (colour == 3'd2) n2++;
      end
    tick;
    check("done_pulse", done, 1);
    check("we_done", writeEn, 0);
    tick;
    check("done_drop", done, 0);
    check("busy_drop", busy, 0);
    if (!item && !erase) begin
      check("border_count", n6, 60);
      check("interior_count", n2, 196);
    end
  endtask
  task automatic null_req(input logic item, input logic [2:0] pos);
    send(item, 1'b0, pos);
    check("null_busy", busy, 1);
    check("null_we0", writeEn, 0);
    check("null_done0", done, 0);
    tick;
    check("null_done1", done, 1);
    check("null_we1", writeEn, 0);
    tick;
    check("null_done2", done, 0);
    check("null_busy2", busy, 0);
    check("null_we2", writeEn, 0);
    check("null_ready2", req_ready, 1);
  endtask
  initial begin
    int plots, dones;
    req_valid = 1'b1; req_item = 1'b1; req_position = 3'd0;
    repeat (3) tick;
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_colour", colour, 0);
    check("rst_we", writeEn, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 1);
    reset_n = 1'b1; req_valid = 1'b0;
    tick;
    check("rst_req_ignored_busy", busy, 0);
    check("rst_req_ignored_we", writeEn, 0);
    draw(1'b1, 1'b0, 3'd5);
    draw(1'b0, 1'b0, 3'd2);
    null_req(1'b0, 3'd7);
    null_req(1'b1, 3'd6);
    // A accepted at edge 0, B at edge 11, C offered while B is pending
    send(1'b1, 1'b0, 3'd0);
    plots = 0; dones = 0;
    for (int n = 1; n <= 530; n++) begin
      if (n == 11) begin req_valid = 1'b1; req_item = 1'b1; req_erase = 1'b1; req_position = 3'd0; end
      if (n == 12) begin
        check("q_ready_pend", req_ready, 0);
        req_item = 1'b0; req_erase = 1'b0; req_position = 3'd1;
      end
      if (n == 21) req_valid = 1'b0;
      tick;
      plots += int'(writeEn); dones += int'(done);
      if (n == 1) begin
        check("q_a_x", x, 8); check("q_a_y", y, 20); check("q_a_colour", colour, 7);
      end
      if (n == 257) begin check("q_gap_we", writeEn, 0); check("q_gap_done", done, 1); end
      if (n == 258) begin
        check("q_b_we", writeEn, 1); check("q_b_x", x, 8); check("q_b_y", y, 20); check("q_b_colour", colour, 0);
      end
      if (n == 514) check("q_b_done", done, 1);
    end
    check("q_plots", plots, 512);
    check("q_dones", dones, 2);
    send(1'b1, 1'b0, 3'd1);
    for (int n = 1; n <= 101; n++) begin
      req_valid = n == 5;
      tick;
    end
    check("r_we_pix100", writeEn, 1);
    check("r_x_pix100", x, 36);
    check("r_y_pix100", y, 26);
    reset_n = 1'b0;
    tick;
    check("r_we", writeEn, 0);
    check("r_done", done, 0);
    check("r_busy", busy, 0);
    check("r_ready", req_ready, 1);
    tick;
    reset_n = 1'b1;
    plots = 0; dones = 0;
    repeat (400) begin
      tick;
      plots += int'(writeEn); dones += int'(done);
    end
    check("r_no_plots", plots, 0);
    check("r_no_done", dones, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
